// File: rtl/aha_ahb_code_sram_bridge.sv
// aha_ahb_code_sram_bridge
// Zero-wait-state AHB-Lite slave for CM3 merged I/D-Code traffic, driving one
// single-port synchronous SRAM (active-low enables). Writes are parked in a
// one-entry buffer and drained to SRAM when the port is free. Reads always
// win the port, and a read of the buffered word gets the buffered bytes
// merged over the SRAM data.
module aha_ahb_code_sram_bridge #(
    parameter int AW = 15
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HADDR,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic [1:0]    HRESP,
    output logic [31:0]   HRDATA,
    output logic          SRAM_CEN,
    output logic [3:0]    SRAM_WEN,
    output logic [AW-1:0] SRAM_A,
    output logic [31:0]   SRAM_D,
    input  logic [31:0]   SRAM_Q
);

    // Address-phase decode
    logic          acc;
    logic          rd_acc;
    logic          wr_acc;
    logic [AW-1:0] addr_word;
    logic [3:0]    mask;

    // Write buffer state
    logic          buf_valid;
    logic          wr_pend;
    logic [AW-1:0] buf_addr;
    logic [3:0]    buf_mask;
    logic [31:0]   buf_data;
    logic [31:0]   buf_data_eff;
    logic          flush;

    // Read data-phase state
    logic          rd_pend;
    logic          hit;
    logic [3:0]    hmask;

    // Last values driven onto the SRAM address/data pins (held while idle)
    logic [AW-1:0] sram_a_q;
    logic [31:0]   sram_d_q;

    // Address bits above the SRAM window and HTRANS[0] carry no meaning here
    logic          unused_bits;
    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 2'b00;

    assign acc       = HSEL & HREADY & HTRANS[1];
    assign rd_acc    = acc & ~HWRITE;
    assign wr_acc    = acc & HWRITE;
    assign addr_word = HADDR[AW+1:2];

    // Byte lanes touched by the current transfer
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        mask = 4'b1111;
        if (HSIZE == 3'd0) begin
            mask = 4'b0001 << HADDR[1:0];
        end else if (HSIZE == 3'd1) begin
            mask = HADDR[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Buffer contents with the in-flight write data merged in, so a drain that
    // lands on a write data phase (back-to-back writes) sends complete data
    always_comb begin
        buf_data_eff = buf_data;
        for (int i = 0; i < 4; i++) begin
            if (wr_pend && buf_mask[i]) begin
                buf_data_eff[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // Drain when the port is free; a new write address phase forces the drain
    // of the older entry even while its data phase is still on HWDATA
    assign flush = buf_valid & ~rd_acc & (~wr_pend | wr_acc);

    // SRAM port mux: read first, then drain, else idle with pins held
    always_comb begin
        SRAM_CEN = 1'b1;
        SRAM_WEN = 4'hF;
        SRAM_A   = sram_a_q;
        SRAM_D   = sram_d_q;
        if (rd_acc) begin
            SRAM_CEN = 1'b0;
            SRAM_A   = addr_word;
        end else if (flush) begin
            SRAM_CEN = 1'b0;
            SRAM_WEN = ~buf_mask;
            SRAM_A   = buf_addr;
            SRAM_D   = buf_data_eff;
        end
    end

    // Remember the last SRAM address/data so idle cycles keep the pins stable
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sram_a_q <= '0;
            sram_d_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sram_a_q <= SRAM_A;
            sram_d_q <= SRAM_D;
        end
    end

    // Buffer control: valid bit and write data-phase tracking
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            buf_valid <= 1'b0;
            wr_pend   <= 1'b0;
        end else begin
            wr_pend <= wr_acc;
            if (wr_acc) begin
                buf_valid <= 1'b1;
            end else if (flush) begin
                buf_valid <= 1'b0;
            end
        end
    end

    // Buffer payload: address and lane mask at the address phase, data at the data phase
    // NOTE: payload registers are qualified by buf_valid, so they carry no reset; a reset only clears the valid bit.
    always_ff @(posedge HCLK) begin
        if (wr_acc) begin
            buf_addr <= addr_word;
            buf_mask <= mask;
        end
        if (wr_pend) begin
            buf_data <= buf_data_eff;
        end
    end

    // Capture the forwarding decision at the read address phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_pend <= 1'b0;
            hit     <= 1'b0;
            hmask   <= 4'b0000;
        end else begin
            rd_pend <= rd_acc;
            if (rd_acc) begin
                hit   <= buf_valid && (buf_addr == addr_word);
                hmask <= buf_mask;
            end
        end
    end

    // Read data phase: buffered bytes override SRAM bytes on a hit
    always_comb begin
        HRDATA = 32'h0;
        if (rd_pend) begin
            for (int i = 0; i < 4; i++) begin
                HRDATA[8*i +: 8] = (hit && hmask[i]) ? buf_data[8*i +: 8] : SRAM_Q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_aha_ahb_code_sram_bridge.sv
// Directed bench for aha_ahb_code_sram_bridge with a small SRAM model that
// counts every SRAM write strobe.
`timescale 1ns/1ps
module tb_aha_ahb_code_sram_bridge;

    localparam int AW = 15;

    logic          HCLK    = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL    = 1'b1;
    logic          HREADY  = 1'b1;
    logic [1:0]    HTRANS  = 2'b00;
    logic [2:0]    HSIZE   = 3'd0;
    logic          HWRITE  = 1'b0;
    logic [31:0]   HADDR   = 32'h0;
    logic [31:0]   HWDATA  = 32'h0;
    logic          HREADYOUT;
    logic [1:0]    HRESP;
    logic [31:0]   HRDATA;
    logic          SRAM_CEN;
    logic [3:0]    SRAM_WEN;
    logic [AW-1:0] SRAM_A;
    logic [31:0]   SRAM_D;
    logic [31:0]   sram_q = 32'h0;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;
    int base;

    logic [31:0] mem [0:255] = '{default: 32'h0};

    always #5 HCLK = ~HCLK;

    aha_ahb_code_sram_bridge #(.AW(AW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .SRAM_CEN  (SRAM_CEN),
        .SRAM_WEN  (SRAM_WEN),
        .SRAM_A    (SRAM_A),
        .SRAM_D    (SRAM_D),
        .SRAM_Q    (sram_q)
    );

    // Synchronous SRAM model, read-first, per-byte active-low write enables
    always @(posedge HCLK) begin
        if (!SRAM_CEN) begin
            sram_q <= mem[SRAM_A[7:0]];
            if (SRAM_WEN != 4'hF) begin
                wr_count <= wr_count + 1;
                for (int i = 0; i < 4; i++) begin
                    if (!SRAM_WEN[i]) mem[SRAM_A[7:0]][8*i +: 8] <= SRAM_D[8*i +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Set up one bus cycle (address phase + HWDATA for the previous write), then settle
    task automatic drive(input logic xfer, input logic wr, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        HTRANS = xfer ? 2'b10 : 2'b00;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
        HWDATA = wdata;
        #2;
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Word write through the bridge followed by an idle cycle that drains it
    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, 1'b1, 3'd2, addr, 32'h0); step();
        drive(1'b0, 1'b0, 3'd2, addr, data);  step();
        drive(1'b0, 1'b0, 3'd2, addr, 32'h0); step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset values
        #3;
        check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        check("rst_hresp",     32'(HRESP),     32'h0);
        check("rst_hrdata",    HRDATA,         32'h0);
        check("rst_cen",       32'(SRAM_CEN),  32'h1);
        check("rst_wen",       32'(SRAM_WEN),  32'hF);
        check("rst_a",         32'(SRAM_A),    32'h0);
        check("rst_d",         SRAM_D,         32'h0);
        step();
        HRESETn = 1'b1;

        // Word write 0x100, two idle cycles, then read back
        base = wr_count;
        drive(1'b1, 1'b1, 3'd2, 32'h100, 32'h0);        check("t1_wa_cen", 32'(SRAM_CEN), 32'h1); step();
        drive(1'b0, 1'b0, 3'd2, 32'h100, 32'hDEADBEEF); check("t1_wd_cen", 32'(SRAM_CEN), 32'h1); step();
        drive(1'b0, 1'b0, 3'd2, 32'h100, 32'h0);
        check("t1_fl_cen", 32'(SRAM_CEN), 32'h0);
        check("t1_fl_wen", 32'(SRAM_WEN), 32'h0);
        check("t1_fl_a",   32'(SRAM_A),   32'h40);
        check("t1_fl_d",   SRAM_D,        32'hDEADBEEF);
        step();
        drive(1'b0, 1'b0, 3'd2, 32'h100, 32'h0);
        check("t1_idle_cen",  32'(SRAM_CEN), 32'h1);
        check("t1_idle_hold", 32'(SRAM_A),   32'h40);
        step();
        check("t1_wr_count", 32'(wr_count - base), 32'h1);
        drive(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
        check("t1_rd_cen", 32'(SRAM_CEN), 32'h0);
        check("t1_rd_wen", 32'(SRAM_WEN), 32'hF);
        check("t1_rd_a",   32'(SRAM_A),   32'h40);
        step();
        drive(1'b0, 1'b0, 3'd2, 32'h100, 32'h0);
        check("t1_rdata", HRDATA, 32'hDEADBEEF);
        step();

        // Byte write forwarded into a back-to-back read of the same word
        preload(32'h100, 32'h11223344);
        drive(1'b1, 1'b1, 3'd0, 32'h102, 32'h0); step();
        drive(1'b1, 1'b0, 3'd2, 32'h100, 32'h00AA0000);
        check("t2_rd_cen", 32'(SRAM_CEN), 32'h0);
        check("t2_rd_wen", 32'(SRAM_WEN), 32'hF);
        step();
        drive(1'b0, 1'b0, 3'd2, 32'h100, 32'h0);
        check("t2_fwd_rdata", HRDATA, 32'h11AA3344);
        check("t2_fl_wen",    32'(SRAM_WEN), 32'hB);
        check("t2_fl_a",      32'(SRAM_A),   32'h40);
        step();
        drive(1'b1, 1'b0, 3'd2, 32'h100, 32'h0); step();
        drive(1'b0, 1'b0, 3'd2, 32'h100, 32'h0);
        check("t2_sram_rdata", HRDATA, 32'h11AA3344);
        step();

        // A read stream holds the buffer; drain on the first free cycle
        preload(32'h300, 32'h5A5A1234);
        drive(1'b1, 1'b1, 3'd2, 32'h200, 32'h0); step();
        base = wr_count;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 3'd2, 32'h300, (i == 0) ? 32'hCAFEF00D : 32'h0);
            check("t3_rd_wen", 32'(SRAM_WEN), 32'hF);
            if (i == 1) check("t3_rdata", HRDATA, 32'h5A5A1234);
            step();
        end
        drive(1'b0, 1'b0, 3'd2, 32'h300, 32'h0);
        check("t3_last_rdata", HRDATA, 32'h5A5A1234);
        check("t3_no_wr",      32'(wr_count - base), 32'h0);
        check("t3_fl_cen",     32'(SRAM_CEN), 32'h0);
        check("t3_fl_wen",     32'(SRAM_WEN), 32'h0);
        check("t3_fl_a",       32'(SRAM_A),   32'h80);
        check("t3_fl_d",       SRAM_D,        32'hCAFEF00D);
        step();

        // Back-to-back writes: older entry drains in the next address phase
        drive(1'b1, 1'b1, 3'd2, 32'h10, 32'h0);
        check("t4_a_cen",   32'(SRAM_CEN),  32'h1);
        check("t4_a_ready", 32'(HREADYOUT), 32'h1);
        step();
        drive(1'b1, 1'b1, 3'd2, 32'h14, 32'h01010101);
        check("t4_b_cen",   32'(SRAM_CEN),  32'h0);
        check("t4_b_wen",   32'(SRAM_WEN),  32'h0);
        check("t4_b_a",     32'(SRAM_A),    32'h4);
        check("t4_b_d",     SRAM_D,         32'h01010101);
        check("t4_b_ready", 32'(HREADYOUT), 32'h1);
        step();
        drive(1'b0, 1'b0, 3'd2, 32'h14, 32'h02020202);
        check("t4_c_cen",   32'(SRAM_CEN),  32'h1);
        check("t4_c_ready", 32'(HREADYOUT), 32'h1);
        step();
        drive(1'b0, 1'b0, 3'd2, 32'h14, 32'h0);
        check("t4_d_a",     32'(SRAM_A),    32'h5);
        check("t4_d_d",     SRAM_D,         32'h02020202);
        check("t4_d_wen",   32'(SRAM_WEN),  32'h0);
        step();

        // Halfword write to the upper half
        preload(32'h20, 32'h12345678);
        drive(1'b1, 1'b1, 3'd1, 32'h22, 32'h0); step();
        drive(1'b0, 1'b0, 3'd1, 32'h22, 32'hBEEF0000);
        check("t5_wd_cen", 32'(SRAM_CEN), 32'h1);
        step();
        drive(1'b0, 1'b0, 3'd2, 32'h20, 32'h0);
        check("t5_fl_cen",  32'(SRAM_CEN),      32'h0);
        check("t5_fl_wen",  32'(SRAM_WEN),      32'h3);
        check("t5_fl_a",    32'(SRAM_A),        32'h8);
        check("t5_fl_dhi",  32'(SRAM_D[31:16]), 32'hBEEF);
        step();
        drive(1'b1, 1'b0, 3'd2, 32'h20, 32'h0); step();
        drive(1'b0, 1'b0, 3'd2, 32'h20, 32'h0);
        check("t5_rdata_hi", 32'(HRDATA[31:16]), 32'hBEEF);
        check("t5_rdata",    HRDATA,             32'hBEEF5678);
        step();

        // Reset during a write data phase discards the write
        preload(32'hC0, 32'hA5A5A5A5);
        base = wr_count;
        drive(1'b1, 1'b1, 3'd2, 32'hC0, 32'h0); step();
        drive(1'b0, 1'b0, 3'd2, 32'hC0, 32'hFFFFFFFF);
        HRESETn = 1'b0;
        #1;
        check("t6_rst_cen", 32'(SRAM_CEN), 32'h1);
        step();
        drive(1'b0, 1'b0, 3'd2, 32'hC0, 32'h0);
        HRESETn = 1'b1;
        check("t6_rel_cen", 32'(SRAM_CEN), 32'h1);
        step();
        drive(1'b0, 1'b0, 3'd2, 32'hC0, 32'h0);
        check("t6_post_cen1", 32'(SRAM_CEN), 32'h1);
        step();
        drive(1'b0, 1'b0, 3'd2, 32'hC0, 32'h0);
        check("t6_post_cen2", 32'(SRAM_CEN), 32'h1);
        step();
        check("t6_no_wr", 32'(wr_count - base), 32'h0);
        drive(1'b1, 1'b0, 3'd2, 32'hC0, 32'h0); step();
        drive(1'b0, 1'b0, 3'd2, 32'hC0, 32'h0);
        check("t6_rdata", HRDATA, 32'hA5A5A5A5);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
